// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill sequencer: one line request per miss, beat collection
// into a line buffer, then a single-cycle line write. Flush cancels or discards.
module icache_refill_ctrl #(
    parameter int ADR_WIDTH  = 32,
    parameter int LINE_BYTES = 32,
    parameter int BUS_BYTES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    miss_valid,
    input  logic [ADR_WIDTH-1:0]    miss_adr,
    input  logic                    flush,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADR_WIDTH-1:0]    mem_req_adr,
    input  logic                    mem_rsp_valid,
    input  logic [BUS_BYTES*8-1:0]  mem_rsp_data,
    output logic                    line_wr_en,
    output logic [ADR_WIDTH-1:0]    line_wr_adr,
    output logic [LINE_BYTES*8-1:0] line_wr_data,
    output logic                    busy,
    output logic                    refill_done
);

    localparam int BEATS = LINE_BYTES / BUS_BYTES;
    localparam int CW    = $clog2(BEATS);
    localparam int OW    = $clog2(LINE_BYTES);
    localparam int BW    = BUS_BYTES * 8;

    typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_e;

    state_e                  state_q;
    logic [ADR_WIDTH-1:0]    adr_q;
    logic [LINE_BYTES*8-1:0] buf_q;
    logic [CW-1:0]           cnt_q;
    logic                    discard_q;
    logic                    req_valid_q;
    logic                    wr_en_q;
    logic                    done_q;
    logic                    busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            req_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (miss_valid && !flush) begin
                        adr_q       <= {miss_adr[ADR_WIDTH-1:OW], {OW{1'b0}}};
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                REQ: begin
                    // A handshake wins over a coincident flush: the request
                    // is already on its way, so its beats must be drained.
                    if (mem_req_ready) begin
                        state_q     <= RECV;
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        discard_q   <= flush;
                    end else if (flush) begin
                        state_q     <= IDLE;
                        req_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                RECV: begin
                    if (flush) begin
                        discard_q <= 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        buf_q[int'(cnt_q)*BW +: BW] <= mem_rsp_data;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(BEATS - 1)) begin
                            discard_q <= 1'b0;
                            if (discard_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= WRITE;
                                wr_en_q <= 1'b1;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_adr   = adr_q;
    assign line_wr_en    = wr_en_q;
    assign line_wr_adr   = adr_q;
    assign line_wr_data  = buf_q;
    assign refill_done   = done_q;
    assign busy          = busy_q;

    a_rsp_only_in_recv: assert property (
        @(posedge clk) disable iff (!rst_n)
        mem_rsp_valid |-> (state_q == RECV)
    );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: expected requests and line
// writes are queued by the stimulus and popped by a negedge monitor.
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_valid;
    logic [31:0]  miss_adr;
    logic         flush;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_adr;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         line_wr_en;
    logic [31:0]  line_wr_adr;
    logic [255:0] line_wr_data;
    logic         busy;
    logic         refill_done;

    typedef struct {
        logic [31:0]  adr;
        logic [255:0] data;
    } wr_t;

    logic [31:0] req_q[$];
    wr_t         wr_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    icache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_adr(miss_adr), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_adr(mem_req_adr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .line_wr_en(line_wr_en), .line_wr_adr(line_wr_adr),
        .line_wr_data(line_wr_data), .busy(busy), .refill_done(refill_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_val(input logic [31:0] seed, input int i);
        return seed + 32'(i + 1) * 32'h1111_1111;
    endfunction

    function automatic logic [255:0] line_val(input logic [31:0] seed);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = beat_val(seed, i);
        return l;
    endfunction

    // Monitor: compares every handshake and every write against the queues.
    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            if (req_q.size() == 0) chk("unexpected_req", 256'(mem_req_adr), 256'hx);
            else chk("req_adr", 256'(mem_req_adr), 256'(req_q.pop_front()));
        end
        if (line_wr_en) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 256'(line_wr_adr), 256'hx);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_adr", 256'(line_wr_adr), 256'(e.adr));
                chk("wr_data", line_wr_data, e.data);
                chk("wr_done", 256'(refill_done), 256'(1));
            end
        end else if (refill_done) begin
            chk("done_without_wr", 256'(refill_done), 256'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_miss(input logic [31:0] a);
        miss_valid = 1'b1;
        miss_adr   = a;
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] seed, input int i);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = beat_val(seed, i);
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] seed);
        wr_t e;
        e.adr  = a;
        e.data = line_val(seed);
        wr_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, 256'(busy), 256'(0));
        chk({nm, "_req_valid"}, 256'(mem_req_valid), 256'(0));
        chk({nm, "_wr_en"}, 256'(line_wr_en), 256'(0));
        chk({nm, "_done"}, 256'(refill_done), 256'(0));
        chk({nm, "_req_adr"}, 256'(mem_req_adr), 256'(0));
        chk({nm, "_wr_adr"}, 256'(line_wr_adr), 256'(0));
        chk({nm, "_wr_data"}, line_wr_data, 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; miss_valid = 1'b0; miss_adr = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic refill, ready always high
        mem_req_ready = 1'b1;
        req_q.push_back(32'h0000_1220);
        push_wr(32'h0000_1220, 32'h0);
        issue_miss(32'h0000_1234);
        chk("t1_req_valid", 256'(mem_req_valid), 256'(1));
        chk("t1_req_adr", 256'(mem_req_adr), 256'h1220);
        tick();
        chk("t1_req_drop", 256'(mem_req_valid), 256'(0));
        for (int i = 0; i < 8; i++) send_beat(32'h0, i);
        chk("t1_wr_latency", 256'(line_wr_en), 256'(1));
        tick();
        chk("t1_wr_pulse", 256'(line_wr_en), 256'(0));
        chk("t1_idle", 256'(busy), 256'(0));

        // Backpressure on request, gaps between beats
        mem_req_ready = 1'b0;
        req_q.push_back(32'h0000_4000);
        push_wr(32'h0000_4000, 32'h0A00_0000);
        issue_miss(32'h0000_4013);
        for (int c = 0; c < 3; c++) begin
            chk("t2_req_hold", 256'(mem_req_valid), 256'(1));
            chk("t2_adr_hold", 256'(mem_req_adr), 256'h4000);
            tick();
        end
        mem_req_ready = 1'b1;
        chk("t2_req_hold4", 256'(mem_req_valid), 256'(1));
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_beat(32'h0A00_0000, i);
            if (i % 2 == 1 && i != 7) begin tick(); tick(); end
        end
        tick(); tick();

        // Flush in REQ without ready
        issue_miss(32'h0000_5000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_busy", 256'(busy), 256'(0));
        chk("t3_req_valid", 256'(mem_req_valid), 256'(0));
        req_q.push_back(32'h0000_2000);
        push_wr(32'h0000_2000, 32'h0B00_0000);
        issue_miss(32'h0000_2000);
        chk("t3_new_adr", 256'(mem_req_adr), 256'h2000);
        mem_req_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send_beat(32'h0B00_0000, i);
        tick();

        // Flush coincident with the request handshake: drain and discard
        req_q.push_back(32'h0000_6000);
        issue_miss(32'h0000_6004);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(32'h0C00_0000, i);
        chk("t4_busy", 256'(busy), 256'(0));
        tick();

        // Flush after beat 3 in RECV
        req_q.push_back(32'h0000_7000);
        issue_miss(32'h0000_7008);
        tick();
        for (int i = 0; i < 3; i++) send_beat(32'h0D00_0000, i);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 3; i < 8; i++) begin
            if (i == 7) chk("t5_busy_before", 256'(busy), 256'(1));
            send_beat(32'h0D00_0000, i);
        end
        chk("t5_busy_after", 256'(busy), 256'(0));
        tick();

        // Miss during RECV is ignored
        req_q.push_back(32'h0000_8000);
        push_wr(32'h0000_8000, 32'h0E00_0000);
        issue_miss(32'h0000_801C);
        tick();
        for (int i = 0; i < 8; i++) begin
            send_beat(32'h0E00_0000, i);
            if (i == 2) issue_miss(32'h0000_3000);
        end
        tick(); tick(); tick();

        // Asynchronous reset mid-refill
        req_q.push_back(32'h0000_9000);
        issue_miss(32'h0000_9000);
        tick();
        for (int i = 0; i < 4; i++) send_beat(32'h0F00_0000, i);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        req_q.push_back(32'h0000_A000);
        push_wr(32'h0000_A000, 32'h1000_0000);
        issue_miss(32'h0000_A010);
        tick();
        for (int i = 0; i < 8; i++) send_beat(32'h1000_0000, i);
        tick(); tick();

        chk("req_q_empty", 256'(req_q.size()), 256'(0));
        chk("wr_q_empty", 256'(wr_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
